// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO word packer/unpacker pair: tag placement and
// the unpacker state encoding.
package fifo_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // EOF tag sits directly above the payload in every FIFO word.
    function automatic int tag_pos(input int nslice, input int slicewidth);
        return nslice * slicewidth;
    endfunction

endpackage

// File: rtl/fifo_unpack_mux.sv
// Combinational slice selector: picks slice i_idx of a wide payload, with the
// slice ordering chosen by MSB_FIRST.
module fifo_unpack_mux #(
    parameter int SLICEWIDTH = 8,
    parameter int NSLICE     = 2,
    parameter int MSB_FIRST  = 1,
    parameter int IW         = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
    input  logic [NSLICE*SLICEWIDTH-1:0] i_payload,
    input  logic [IW-1:0]                i_idx,
    output logic [SLICEWIDTH-1:0]        o_slice
);

    // Out-of-range indices yield zero.
    always_comb begin
        o_slice = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (i_idx == IW'(k)) begin
                o_slice = i_payload[((MSB_FIRST != 0) ? (NSLICE - 1 - k) : k) * SLICEWIDTH +: SLICEWIDTH];
            end
        end
    end

endmodule

// File: rtl/fifo_unpack.sv
// Pops tagged wide words from the FIFO's registered read port and streams them
// out as narrow slices, flagging the last slice of EOF-tagged words.
module fifo_unpack
    import fifo_pkg::*;
#(
    parameter int SLICEWIDTH = 8,
    parameter int NSLICE     = 2,
    parameter int MSB_FIRST  = 1,
    parameter int CNTWIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NSLICE*SLICEWIDTH:0]     fifo_rd_data,
    input  logic                           fifo_ne,
    output logic                           fifo_re,
    output logic [SLICEWIDTH-1:0]          out_data,
    output logic                           out_valid,
    output logic                           out_last,
    input  logic                           out_ready,
    output logic                           busy,
    output logic [CNTWIDTH-1:0]            frame_cnt
);

    localparam int PW   = NSLICE * SLICEWIDTH;
    localparam int TAGB = tag_pos(NSLICE, SLICEWIDTH);
    localparam int IW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    if (NSLICE < 2) begin : g_nslice_chk
        $error("fifo_unpack: NSLICE must be >= 2");
    end

    state_t              r_state;
    logic [PW-1:0]       r_pay;
    logic                r_tag;
    logic [IW-1:0]       r_idx;
    logic [SLICEWIDTH-1:0] r_data;
    logic                r_valid;
    logic                r_last;
    logic [CNTWIDTH-1:0] r_cnt;

    logic                w_acc;
    logic                w_at_last;
    logic [IW-1:0]       w_idx_nxt;
    logic [SLICEWIDTH-1:0] w_slice_nxt;
    logic [SLICEWIDTH-1:0] w_slice_new;
    logic                w_re;

    assign w_acc     = r_valid & out_ready;
    assign w_at_last = (r_idx == LAST_IDX);
    assign w_idx_nxt = r_idx + IW'(1);

    // Output data is registered, so look one slice ahead of the held word and
    // at slice 0 of the FIFO head for the reload path.
    fifo_unpack_mux #(
        .SLICEWIDTH(SLICEWIDTH), .NSLICE(NSLICE), .MSB_FIRST(MSB_FIRST), .IW(IW)
    ) u_mux_nxt (
        .i_payload(r_pay), .i_idx(w_idx_nxt), .o_slice(w_slice_nxt)
    );

    fifo_unpack_mux #(
        .SLICEWIDTH(SLICEWIDTH), .NSLICE(NSLICE), .MSB_FIRST(MSB_FIRST), .IW(IW)
    ) u_mux_new (
        .i_payload(fifo_rd_data[PW-1:0]), .i_idx('0), .o_slice(w_slice_new)
    );

    // Pop uses only the FIFO's registered not-empty, so no loop through re.
    always_comb begin
        w_re = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_IDLE:   w_re = fifo_ne;
                ST_ACTIVE: w_re = w_acc & w_at_last & fifo_ne;
                default:   w_re = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pay   <= '0;
            r_tag   <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_acc && r_last) begin
                r_cnt <= r_cnt + CNTWIDTH'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_re) begin
                        r_pay   <= fifo_rd_data[PW-1:0];
                        r_tag   <= fifo_rd_data[TAGB];
                        r_idx   <= '0;
                        r_data  <= w_slice_new;
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_acc) begin
                        if (!w_at_last) begin
                            r_idx  <= w_idx_nxt;
                            r_data <= w_slice_nxt;
                            r_last <= r_tag & (w_idx_nxt == LAST_IDX);
                        end else if (w_re) begin
                            r_pay  <= fifo_rd_data[PW-1:0];
                            r_tag  <= fifo_rd_data[TAGB];
                            r_idx  <= '0;
                            r_data <= w_slice_new;
                            r_last <= 1'b0;
                        end else begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign fifo_re   = w_re;
    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign busy      = (r_state == ST_ACTIVE);
    assign frame_cnt = r_cnt;

endmodule

// File: doc/fifo_unpack.md
Name: fifo_unpack

Overview:
- Downstream consumer of the synchronous FIFO. Pops wide tagged words through the FIFO's registered read interface and emits them as narrow slices on a valid/ready stream.
- Marks the last slice of any tagged word as end-of-frame and counts completed frames.
- Sits between the FIFO and byte-wide sinks such as the UART/SPI transmitters.

Parameters:
- SLICEWIDTH, 8: width of each output slice.
- NSLICE, 2: slices per FIFO word. Must be >= 2; elaboration fails otherwise.
- MSB_FIRST, 1: 1 emits the most-significant slice first; 0 emits the least-significant slice first.
- CNTWIDTH, 16: width of frame_cnt.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- fifo_rd_data  in  NSLICE*SLICEWIDTH+1  head word from FIFO registered read data. Bit [NSLICE*SLICEWIDTH] is the EOF tag; lower bits are payload.
- fifo_ne  in  1  FIFO registered not-empty.
- fifo_re  out  1  FIFO read enable (pop). Combinational.
- out_data  out  SLICEWIDTH  slice data, registered.
- out_valid  out  1  slice valid, registered.
- out_last  out  1  final slice of an EOF-tagged word, registered.
- out_ready  in  1  sink accepts the slice.
- busy  out  1  word held or slice pending, registered.
- frame_cnt  out  CNTWIDTH  number of completed frames, registered.

Behaviour:
- Reset is asynchronous, active-high. While reset is asserted:
  - out_valid=0, out_last=0, out_data=0, busy=0, frame_cnt=0.
  - Slice index=0, state=IDLE, fifo_re=0.
  - A held word is discarded (reset mid-word drops it); nothing is replayed after release.
- Interfaces only with the FIFO's registered ne/rd_data, never the next-state outputs. This avoids a combinational loop through re.
- fifo_rd_data is the current head. Asserting fifo_re at edge t pops it; the new head is visible at t+1.
- Accept: acc = out_valid & out_ready.
- State machine, 2 states:
  - IDLE (no word held):
    - fifo_re = fifo_ne.
    - On fifo_re, capture payload and tag into the hold register, set index=0, go to ACTIVE.
    - out_valid rises the cycle after fifo_re, with slice 0 on out_data.
  - ACTIVE (word held, out_valid=1):
    - On acc with index<NSLICE-1: index+1, present the next slice next cycle.
    - On acc with index==NSLICE-1 and fifo_ne=1: fifo_re=1 this cycle, load the new word, index=0, stay ACTIVE. This is zero-bubble; out_valid stays 1.
    - On acc with index==NSLICE-1 and fifo_ne=0: go to IDLE, out_valid=0 next cycle.
    - No acc: hold everything.
- fifo_re in ACTIVE = acc & (index==NSLICE-1) & fifo_ne.
- fifo_re is never asserted while fifo_ne=0, so underflow is impossible by construction.
- Slice order:
  - MSB_FIRST=1: slice k = payload[(NSLICE-1-k)*SLICEWIDTH +: SLICEWIDTH].
  - MSB_FIRST=0: slice k = payload[k*SLICEWIDTH +: SLICEWIDTH].
- out_last=1 only while presenting index NSLICE-1 of a word whose tag=1.
- out_data, out_valid and out_last are held stable while out_valid=1 and out_ready=0.
- frame_cnt increments by 1 on acc & out_last and wraps modulo 2^CNTWIDTH.
- busy = (state==ACTIVE).
- Throughput: with out_ready held high and the FIFO never empty, one slice per cycle and one pop every NSLICE cycles.
- Latency: fifo_ne rising in IDLE gives out_valid one cycle later.
- out_ready toggling on every cycle must not lose, duplicate or reorder slices.
- out_ready may be asserted while out_valid=0; it has no effect.

Decomposition:
- Shared package fifo_pkg: EOF-tag bit position function (NSLICE*SLICEWIDTH) and state encoding constants ST_IDLE/ST_ACTIVE. The same tag convention is used by the upstream packer.
- One natural sub-module, fifo_unpack_mux: combinational slice selector (payload, index, MSB_FIRST) -> slice. It is reused by the future width-down converters.
- Counter and FSM stay in the top module.

Test Plan:
- Reset/idle: reset asserted with fifo_ne=1 -> fifo_re=0, out_valid=0, frame_cnt=0. Deassert with FIFO empty -> no activity.
- Single word: SLICEWIDTH=8, NSLICE=2, push 0x1_A55A (tag=1), out_ready=1.
  - MSB_FIRST=1 -> slices 0xA5 then 0x5A, out_last only on 0x5A, frame_cnt=1, exactly one fifo_re pulse.
  - MSB_FIRST=0 -> slices 0x5A then 0xA5.
- Streaming: push 8 untagged words 0x0_0000..0x0_0007, out_ready=1 -> 16 consecutive out_valid cycles with no bubbles, fifo_re every 2nd cycle, frame_cnt stays 0.
- Backpressure: the same 8 words with out_ready random at 50% -> the slice sequence matches a reference model exactly, out_data is stable while stalled, and there is no fifo_re while fifo_ne=0.
- Counter wrap: CNTWIDTH=4, send 17 tagged words -> frame_cnt reads 1.
- Reset mid-word: assert reset after slice 0 of word 0x1_BEEF -> outputs return to reset values immediately (asynchronously). After release, the next FIFO word is emitted from slice 0 and 0xEF is never emitted.
